// File: rtl/limit_loader_pkg.sv
// Shared types and constants for the limit loader.
//   state_t       : loader FSM state (IDLE, PEND)
//   DEFAULT_N_RST : terminal count driven after reset
//   TIMER_W       : width of the pending-wait timer
//   TIMEOUT_DEF   : default wait, in cycles, before a forced apply
package limit_loader_pkg;

  localparam int unsigned LIMIT_W = 4;
  localparam int unsigned TIMER_W = 8;

  localparam logic [LIMIT_W-1:0] DEFAULT_N_RST = 4'd9;
  localparam logic [TIMER_W-1:0] TIMEOUT_DEF   = 8'd64;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

endpackage

// File: rtl/limit_loader_pend_timer.sv
// Counts cycles spent waiting for a period start; flags the last one.
//   clk : clock
//   rst : synchronous active-high reset
//   clr : clear the count (accept or apply)
//   en  : count this cycle
//   tc  : count has reached TIMEOUT-1 (combinational)
module pend_timer
  import limit_loader_pkg::*;
#(
  parameter logic [TIMER_W-1:0] TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [TIMER_W-1:0] timer;

  // Saturating count so a stalled timer can never wrap back to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= '0;
    end else if (clr) begin
      timer <= '0;
    end else if (en && (timer != '1)) begin
      timer <= timer + TIMER_W'(1);
    end
  end

  assign tc = (timer == (TIMEOUT - TIMER_W'(1)));

endmodule

// File: rtl/limit_loader.sv
// Loads a new terminal count for a downstream up counter, applying it
// only when the counter sits at 0 (period start) or after a timeout.
//   clk      : clock
//   rst      : synchronous active-high reset
//   in_valid : request offered on in_limit
//   in_limit : requested terminal count
//   in_ready : request can be accepted this cycle (combinational)
//   cnt      : live count from the downstream counter
//   n        : terminal count driven downstream
//   pending  : accepted request awaiting apply
//   applied  : one-cycle pulse, n took a new value
//   forced   : one-cycle pulse, apply caused by timeout
module limit_loader
  import limit_loader_pkg::*;
#(
  parameter logic [LIMIT_W-1:0] DEFAULT_N = DEFAULT_N_RST,
  parameter logic [TIMER_W-1:0] TIMEOUT   = TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] in_limit,
  output logic       in_ready,
  input  logic [3:0] cnt,
  output logic [3:0] n,
  output logic       pending,
  output logic       applied,
  output logic       forced
);

  state_t             state;
  logic [LIMIT_W-1:0] shadow;
  logic               accept;
  logic               tc;
  logic               tmr_en;
  logic               tmr_clr;
  logic               apply_now;
  logic               timeout_now;

  assign in_ready = (state == IDLE) && !rst;
  assign pending  = (state == PEND);
  assign accept   = in_valid && in_ready;

  // The timer only runs while waiting on a nonzero count; cnt==0 wins a tie.
  assign tmr_en      = (state == PEND) && (cnt != 4'd0);
  assign timeout_now = tmr_en && tc;
  assign apply_now   = (state == PEND) && ((cnt == 4'd0) || tc);
  assign tmr_clr     = accept || apply_now;

  pend_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_pend_timer (
    .clk (clk),
    .rst (rst),
    .clr (tmr_clr),
    .en  (tmr_en),
    .tc  (tc)
  );

  // Loader FSM with registered n and apply pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      n       <= DEFAULT_N;
      shadow  <= DEFAULT_N;
      applied <= 1'b0;
      forced  <= 1'b0;
    end else begin
      applied <= 1'b0;
      forced  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            shadow <= in_limit;
            // An unchanged limit needs no wait for period start.
            if (in_limit == n) begin
              applied <= 1'b1;
            end else begin
              state <= PEND;
            end
          end
        end
        PEND: begin
          if (apply_now) begin
            n       <= shadow;
            applied <= 1'b1;
            forced  <= timeout_now;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_limit_loader.sv
module tb_limit_loader;

  localparam logic [3:0] DEF_N   = 4'd9;
  localparam int         TMO     = 64;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_limit;
  logic       in_ready;
  logic [3:0] cnt;
  logic [3:0] n;
  logic       pending;
  logic       applied;
  logic       forced;

  limit_loader #(
    .DEFAULT_N (DEF_N),
    .TIMEOUT   (8'(TMO))
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_limit (in_limit),
    .in_ready (in_ready),
    .cnt      (cnt),
    .n        (n),
    .pending  (pending),
    .applied  (applied),
    .forced   (forced)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  // Behavioural model: a request waits in a slot until the counter is at 0,
  // or until it has sat there for TMO edges.
  int m_n;
  int m_shadow;
  bit m_pend;
  int m_wait;
  bit m_applied;
  bit m_forced;

  typedef struct {
    bit       r;
    bit       v;
    int       lim;
    int       c;
    int       exp_n;
    bit       exp_pend;
    bit       exp_app;
    bit       exp_frc;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic void model_edge(input bit r, input bit v, input int lim, input int c);
    m_applied = 1'b0;
    m_forced  = 1'b0;
    if (r) begin
      m_n = DEF_N; m_shadow = DEF_N; m_pend = 1'b0; m_wait = 0;
    end else if (m_pend) begin
      m_wait++;
      if (c == 0) begin
        m_n = m_shadow; m_applied = 1'b1; m_pend = 1'b0;
      end else if (m_wait == TMO) begin
        m_n = m_shadow; m_applied = 1'b1; m_forced = 1'b1; m_pend = 1'b0;
      end
    end else if (v) begin
      m_shadow = lim;
      if (lim == m_n) m_applied = 1'b1;
      else begin
        m_pend = 1'b1; m_wait = 0;
      end
    end
  endfunction

  // Drive one cycle of inputs, advance model, compare DUT with model.
  task automatic step(input bit r, input bit v, input int lim, input int c);
    rst = r; in_valid = v; in_limit = 4'(lim); cnt = 4'(c);
    @(posedge clk);
    model_edge(r, v, lim, c);
    #1;
    check("n",        int'(n),        m_n);
    check("pending",  int'(pending),  int'(m_pend));
    check("applied",  int'(applied),  int'(m_applied));
    check("forced",   int'(forced),   int'(m_forced));
    check("in_ready", int'(in_ready), int'(!m_pend && !r));
    @(negedge clk);
  endtask

  function automatic vec_t mk(bit r, bit v, int lim, int c, int en, bit ep, bit ea, bit ef);
    vec_t x;
    x.r = r; x.v = v; x.lim = lim; x.c = c;
    x.exp_n = en; x.exp_pend = ep; x.exp_app = ea; x.exp_frc = ef;
    return x;
  endfunction

  initial begin
    int c;
    vectors = 0;
    miscompares = 0;
    m_n = 0; m_shadow = 0; m_pend = 1'b0; m_wait = 0; m_applied = 1'b0; m_forced = 1'b0;
    rst = 1'b1; in_valid = 1'b0; in_limit = 4'd0; cnt = 4'd0;

    // reset
    tbl.push_back(mk(1, 0, 0, 0, 9, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 9, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 9, 0, 0, 0));
    // normal update at period start, with an ignored offer while pending
    tbl.push_back(mk(0, 0, 0, 1, 9, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 2, 9, 0, 0, 0));
    tbl.push_back(mk(0, 1, 5, 3, 9, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4, 9, 1, 0, 0));
    tbl.push_back(mk(0, 1, 2, 5, 9, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 6, 9, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 7, 9, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 8, 9, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 9, 9, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 5, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 5, 0, 0, 0));
    // equal value: pulse without pending
    tbl.push_back(mk(0, 1, 5, 2, 5, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 3, 5, 0, 0, 0));
    // accept coincident with cnt==0 waits for the next period start
    tbl.push_back(mk(0, 1, 9, 0, 5, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 5, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 9, 0, 1, 0));
    // reset while pending discards request; first edge after reset accepts
    tbl.push_back(mk(0, 1, 3, 4, 9, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 5, 9, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 6, 9, 0, 0, 0));
    tbl.push_back(mk(0, 1, 9, 7, 9, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 8, 9, 0, 0, 0));

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].v, tbl[i].lim, tbl[i].c);
      check($sformatf("tbl%0d_n", i),       int'(n),       tbl[i].exp_n);
      check($sformatf("tbl%0d_pending", i), int'(pending), int'(tbl[i].exp_pend));
      check($sformatf("tbl%0d_applied", i), int'(applied), int'(tbl[i].exp_app));
      check($sformatf("tbl%0d_forced", i),  int'(forced),  int'(tbl[i].exp_frc));
    end

    // timeout: cnt held at 7, apply forced on the 64th edge in PEND
    step(0, 1, 12, 7);
    for (int k = 1; k <= TMO; k++) begin
      step(0, 0, 0, 7);
      if (k < TMO) begin
        check("tmo_wait_pending", int'(pending), 1);
        check("tmo_wait_n", int'(n), 9);
      end
    end
    check("tmo_n", int'(n), 12);
    check("tmo_applied", int'(applied), 1);
    check("tmo_forced", int'(forced), 1);
    check("tmo_idle", int'(pending), 0);
    step(0, 0, 0, 7);
    check("tmo_pulse_end", int'(applied) + int'(forced), 0);

    // cnt==0 on the timeout edge: normal apply, not forced
    step(0, 1, 4, 7);
    for (int k = 1; k < TMO; k++) step(0, 0, 0, 7);
    step(0, 0, 0, 0);
    check("tie_n", int'(n), 4);
    check("tie_applied", int'(applied), 1);
    check("tie_forced", int'(forced), 0);

    // randomized traffic: alternate counter sweeps and long stalls
    c = 0;
    for (int blk = 0; blk < 10; blk++) begin
      for (int k = 0; k < 200; k++) begin
        if (blk % 2 == 0) c = (c + 1) % 10;
        else c = ($urandom_range(0, 99) == 0) ? 0 : int'($urandom_range(1, 15));
        step(($urandom_range(0, 63) == 0), $urandom_range(0, 1) == 1,
             int'($urandom_range(0, 15)), c);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
